axi4_slave_read_responder: RTL

Synthesizable AXI4 read-channel responder. It is the slave end of the AR/R channels that the master agent drives.
- Accepts AR requests and returns R bursts from an internal word-addressed memory.
- Supports FIXED, INCR and WRAP bursts, with per-beat OKAY, SLVERR and DECERR responses.
- Used as a DUT-side read target for read sequences and for scoreboard read-data checks.

---
 rtl/axi4_slave_read_responder_pkg.sv | 49 ++++
 rtl/axi4_rd_addr_gen.sv | 30 +++
 rtl/axi4_slave_read_responder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/axi4_slave_read_responder_pkg.sv
// Shared AXI4 read-channel encodings and the burst next-address function.
package axi4_slave_read_responder_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } arburst_e;

   typedef enum logic [2:0] {
      SIZE_1B, SIZE_2B, SIZE_4B, SIZE_8B, SIZE_16B, SIZE_32B, SIZE_64B, SIZE_128B
   } arsize_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } rresp_e;

   // Bit n set means a WRAP burst with arlen=n is legal (2, 4, 8 or 16 beats).
   localparam logic [15:0] WRAP_LEGAL_LEN_MASK = 16'h808A;

   // Wide enough for any practical address bus; callers truncate the result.
   localparam int unsigned NEXT_ADDR_W = 64;

   function automatic logic [NEXT_ADDR_W-1:0] axi4_next_addr(
      input logic [NEXT_ADDR_W-1:0] addr,
      input arsize_e                size,
      input logic [7:0]             len,
      input arburst_e               burst
   );
      logic [NEXT_ADDR_W-1:0] bytes;
      logic [NEXT_ADDR_W-1:0] wrap_size;
      logic [NEXT_ADDR_W-1:0] lower;
      logic [NEXT_ADDR_W-1:0] incr;
      bytes     = NEXT_ADDR_W'(1) << size;
      wrap_size = (NEXT_ADDR_W'(len) + NEXT_ADDR_W'(1)) << size;
      lower     = addr & ~(wrap_size - NEXT_ADDR_W'(1));
      incr      = addr + bytes;
      case (burst)
         BURST_FIXED: return addr;
         BURST_WRAP:  return (incr == lower + wrap_size) ? lower : incr;
         default:     return incr;
      endcase
   endfunction

endpackage

// File: rtl/axi4_rd_addr_gen.sv
// Combinational beat-address stepping plus word-index decode of the current beat address.
module axi4_rd_addr_gen
   import axi4_slave_read_responder_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int MEM_DEPTH     = 1024
) (
   input  logic [ADDRESS_WIDTH-1:0]     addr,
   input  arsize_e                      size,
   input  logic [7:0]                   len,
   input  arburst_e                     burst,
   output logic [ADDRESS_WIDTH-1:0]     next_addr,
   output logic [$clog2(MEM_DEPTH)-1:0] word_idx,
   output logic                         in_range
);

   localparam int BYTE_LSB = $clog2(DATA_WIDTH / 8);
   localparam int MEM_AW   = $clog2(MEM_DEPTH);

   logic [ADDRESS_WIDTH-1:0] word_full;

   // Computed wide so a WRAP window touching the top of the address space still folds back.
   assign next_addr = ADDRESS_WIDTH'(axi4_next_addr(NEXT_ADDR_W'(addr), size, len, burst));

   assign word_full = addr >> BYTE_LSB;
   assign in_range  = (word_full < ADDRESS_WIDTH'(MEM_DEPTH));
   assign word_idx  = word_full[MEM_AW-1:0];

endmodule

// File: rtl/axi4_slave_read_responder.sv
// AXI4 AR/R slave responder: serves FIXED/INCR/WRAP read bursts from a backdoor-loaded word memory.
// Build option AXI4_SLV_RD_AR_FIFO_EN adds a 4-deep AR queue so bursts chain without idle cycles.
module axi4_slave_read_responder
   import axi4_slave_read_responder_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int ID_WIDTH      = 4,
   parameter int MEM_DEPTH     = 1024
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic [ID_WIDTH-1:0]          arid,
   input  logic [ADDRESS_WIDTH-1:0]     araddr,
   input  logic [7:0]                   arlen,
   input  logic [2:0]                   arsize,
   input  logic [1:0]                   arburst,
   input  logic                         arvalid,
   output logic                         arready,
   output logic [ID_WIDTH-1:0]          rid,
   output logic [DATA_WIDTH-1:0]        rdata,
   output logic [1:0]                   rresp,
   output logic                         rlast,
   output logic                         rvalid,
   input  logic                         rready,
   input  logic                         mem_wr_en,
   input  logic [$clog2(MEM_DEPTH)-1:0] mem_wr_addr,
   input  logic [DATA_WIDTH-1:0]        mem_wr_data
);

   localparam int         BYTE_LSB = $clog2(DATA_WIDTH / 8);
   localparam int         MEM_AW   = $clog2(MEM_DEPTH);
   localparam logic [2:0] MAX_SIZE = 3'(BYTE_LSB);

   typedef enum logic {IDLE, BURST} state_e;

   // Everything needed to run a burst; the error class is resolved once, at acceptance.
   typedef struct packed {
      logic [ID_WIDTH-1:0]      id;
      logic [ADDRESS_WIDTH-1:0] addr;
      logic [7:0]               len;
      arsize_e                  size;
      arburst_e                 burst;
      logic                     slv;
      logic                     dec;
   } req_t;

   state_e                   state_q, state_d;
   req_t                     ar_req, ld_req, cur_q;
   logic [7:0]               beats_left_q;
   logic                     arready_q, arready_d;
   logic                     ar_hs, beat_hs, last_hs, load, req_avail;
   logic [ADDRESS_WIDTH-1:0] ar_word, next_addr;
   logic [MEM_AW-1:0]        cur_word;
   logic                     cur_in_range;
   rresp_e                   beat_resp;
   logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH];

   assign ar_hs   = arvalid && arready;
   assign beat_hs = rvalid && rready;
   assign last_hs = beat_hs && rlast;

   // NOTE: defaults come first so every path assigns every output and no latch is inferred.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_avail) begin
               load    = 1'b1;
               state_d = BURST;
            end
         end
         BURST: begin
            if (last_hs) begin
               if (req_avail) load    = 1'b1;
               else           state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   assign ar_word = araddr >> BYTE_LSB;

   always_comb begin
      ar_req.id    = arid;
      ar_req.addr  = araddr;
      ar_req.len   = arlen;
      ar_req.size  = arsize_e'(arsize);
      ar_req.burst = arburst_e'(arburst);
      ar_req.slv   = (arsize > MAX_SIZE) || (ar_req.burst == BURST_RSVD) ||
                     ((ar_req.burst == BURST_WRAP) &&
                      !((arlen[7:4] == 4'd0) && WRAP_LEGAL_LEN_MASK[arlen[3:0]]));
      ar_req.dec   = (ar_word >= ADDRESS_WIDTH'(MEM_DEPTH));
   end

`ifdef AXI4_SLV_RD_AR_FIFO_EN
   localparam int FIFO_DEPTH = 4;

   req_t       fifo_mem [FIFO_DEPTH];
   logic [1:0] wr_ptr_q, rd_ptr_q;
   logic [2:0] count_q, count_d;

   assign req_avail = (count_q != 3'd0);
   assign ld_req    = fifo_mem[rd_ptr_q];
   assign count_d   = count_q + {2'b00, ar_hs} - {2'b00, load};
   assign arready_d = (count_d != 3'(FIFO_DEPTH));

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (ar_hs) wr_ptr_q <= wr_ptr_q + 2'd1;
         if (load)  rd_ptr_q <= rd_ptr_q + 2'd1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge aclk) begin
      if (ar_hs) fifo_mem[wr_ptr_q] <= ar_req;
   end
`else
   // arready is low throughout BURST, so a handshake can only happen in IDLE.
   assign req_avail = ar_hs;
   assign ld_req    = ar_req;
   assign arready_d = (state_d == IDLE);
`endif

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cur_q        <= '0;
         beats_left_q <= '0;
         arready_q    <= 1'b0;
      end else begin
         arready_q <= arready_d;
         if (load) begin
            cur_q        <= ld_req;
            beats_left_q <= ld_req.len;
         end else if (beat_hs) begin
            cur_q.addr <= next_addr;
            if (!rlast) beats_left_q <= beats_left_q - 8'd1;
         end
      end
   end

   axi4_rd_addr_gen #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH),
      .MEM_DEPTH     (MEM_DEPTH)
   ) u_addr_gen (
      .addr      (cur_q.addr),
      .size      (cur_q.size),
      .len       (cur_q.len),
      .burst     (cur_q.burst),
      .next_addr (next_addr),
      .word_idx  (cur_word),
      .in_range  (cur_in_range)
   );

   // INCR bursts running off the top of memory turn DECERR beat by beat.
   always_comb begin
      beat_resp = RESP_OKAY;
      if (cur_q.slv)                       beat_resp = RESP_SLVERR;
      else if (cur_q.dec || !cur_in_range) beat_resp = RESP_DECERR;
   end

   // NOTE: the memory array has no reset; contents survive aresetn and are only set by preload.
   always_ff @(posedge aclk) begin
      if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
   end

   // Read is asynchronous so a preload to the presented word shows on the next cycle.
   assign arready = arready_q;
   assign rvalid  = (state_q == BURST);
   assign rlast   = rvalid && (beats_left_q == 8'd0);
   assign rid     = cur_q.id;
   assign rresp   = rvalid ? beat_resp : RESP_OKAY;
   assign rdata   = (rvalid && (beat_resp == RESP_OKAY)) ? mem[cur_word] : '0;

endmodule
